// File: rtl/value_lock_sequencer.sv
// Acquisition controller for binary_value_prioritizer: clears it, programs its config,
// forwards samples, watches for lock, retries on timeout and reports lock or failure.
module value_lock_sequencer #(
  parameter int unsigned VALUE_BIT_WIDTH   = 8,
  parameter int unsigned COUNT_BIT_WIDTH   = 8,
  parameter int unsigned TIMEOUT_BIT_WIDTH = 16,
  parameter int unsigned MAX_RETRIES       = 3,
  localparam int unsigned RETRY_BIT_WIDTH  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                         clk,
  input  logic                         clk_en,
  input  logic                         sync_rst,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [COUNT_BIT_WIDTH-1:0]   growth_rate_i,
  input  logic [COUNT_BIT_WIDTH-1:0]   decay_rate_i,
  input  logic [COUNT_BIT_WIDTH-1:0]   saturation_limit_i,
  input  logic [COUNT_BIT_WIDTH-1:0]   plateau_limit_i,
  input  logic [TIMEOUT_BIT_WIDTH-1:0] timeout_cycles_i,
  input  logic                         sample_valid_i,
  input  logic [VALUE_BIT_WIDTH-1:0]   sample_data_i,
  output logic                         prio_clear_state_o,
  output logic [COUNT_BIT_WIDTH-1:0]   prio_growth_rate_o,
  output logic [COUNT_BIT_WIDTH-1:0]   prio_decay_rate_o,
  output logic [COUNT_BIT_WIDTH-1:0]   prio_saturation_limit_o,
  output logic [COUNT_BIT_WIDTH-1:0]   prio_plateau_limit_o,
  output logic                         prio_we_o,
  output logic [VALUE_BIT_WIDTH-1:0]   prio_data_o,
  input  logic                         prio_locked_in_i,
  input  logic [VALUE_BIT_WIDTH-1:0]   prio_data_i,
  output logic                         busy_o,
  output logic                         locked_o,
  output logic [VALUE_BIT_WIDTH-1:0]   locked_value_o,
  output logic                         lock_lost_o,
  output logic                         failed_o,
  output logic [RETRY_BIT_WIDTH-1:0]   retry_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_ACQUIRE, ST_LOCKED, ST_FAILED
  } state_e;

  state_e                       state_q, state_d;
  logic [TIMEOUT_BIT_WIDTH-1:0] timer_q, timer_d;
  logic                         timer_en_q, timer_en_d;
  logic [RETRY_BIT_WIDTH-1:0]   retry_q, retry_d;
  logic                         capture_cfg;
  logic                         lost_d;

  logic                         clear_q, busy_q, locked_q, failed_q, lost_q;
  logic [VALUE_BIT_WIDTH-1:0]   locked_value_q;
  logic [COUNT_BIT_WIDTH-1:0]   growth_q, decay_q, sat_q, plateau_q;
  logic                         forwarding;

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    timer_en_d  = timer_en_q;
    retry_d     = retry_q;
    capture_cfg = 1'b0;
    lost_d      = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_FAILED: begin
          if (start_i) begin
            state_d     = ST_CLEAR;
            capture_cfg = 1'b1;
            retry_d     = '0;
          end
        end
        ST_CLEAR: begin
          timer_d    = timeout_cycles_i;
          timer_en_d = |timeout_cycles_i;
          state_d    = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          // Lock takes priority over a timer expiring in the same cycle.
          if (prio_locked_in_i) begin
            state_d = ST_LOCKED;
          end else if (timer_en_q) begin
            if (timer_q == TIMEOUT_BIT_WIDTH'(1)) begin
              if (retry_q < RETRY_BIT_WIDTH'(MAX_RETRIES)) begin
                retry_d = retry_q + RETRY_BIT_WIDTH'(1);
                state_d = ST_CLEAR;
              end else begin
                state_d = ST_FAILED;
              end
            end else begin
              timer_d = timer_q - TIMEOUT_BIT_WIDTH'(1);
            end
          end
        end
        ST_LOCKED: begin
          // Reacquire without clearing so the prioritizer keeps its history.
          if (!prio_locked_in_i) begin
            state_d    = ST_ACQUIRE;
            lost_d     = 1'b1;
            timer_d    = timeout_cycles_i;
            timer_en_d = |timeout_cycles_i;
            retry_d    = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      timer_en_q     <= 1'b0;
      retry_q        <= '0;
      clear_q        <= 1'b0;
      busy_q         <= 1'b0;
      locked_q       <= 1'b0;
      failed_q       <= 1'b0;
      lost_q         <= 1'b0;
      locked_value_q <= '0;
      growth_q       <= '0;
      decay_q        <= '0;
      sat_q          <= '0;
      plateau_q      <= '0;
    end else begin
      lost_q <= clk_en & lost_d;
      if (clk_en) begin
        state_q    <= state_d;
        timer_q    <= timer_d;
        timer_en_q <= timer_en_d;
        retry_q    <= retry_d;
        clear_q    <= (state_d == ST_CLEAR);
        busy_q     <= (state_d == ST_CLEAR) || (state_d == ST_ACQUIRE) || (state_d == ST_LOCKED);
        locked_q   <= (state_d == ST_LOCKED);
        failed_q   <= (state_d == ST_FAILED);
        if (state_q == ST_LOCKED) locked_value_q <= prio_data_i;
        if (capture_cfg) begin
          growth_q  <= growth_rate_i;
          decay_q   <= decay_rate_i;
          sat_q     <= saturation_limit_i;
          plateau_q <= plateau_limit_i;
        end
      end
    end
  end

  // Sample pass-through is combinational so the prioritizer sees data in the same cycle.
  assign forwarding  = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
  assign prio_we_o   = forwarding & sample_valid_i;
  assign prio_data_o = forwarding ? sample_data_i : '0;

  assign prio_clear_state_o      = clear_q;
  assign prio_growth_rate_o      = growth_q;
  assign prio_decay_rate_o       = decay_q;
  assign prio_saturation_limit_o = sat_q;
  assign prio_plateau_limit_o    = plateau_q;
  assign busy_o                  = busy_q;
  assign locked_o                = locked_q;
  assign locked_value_o          = locked_value_q;
  assign lock_lost_o             = lost_q;
  assign failed_o                = failed_q;
  assign retry_count_o           = retry_q;

endmodule

// File: tb/tb_value_lock_sequencer.sv
// Randomized bench for value_lock_sequencer against a cycle-level behavioural model,
// preceded by directed scenarios for reset, lock, retry/fail, lock loss and abort.
module tb_value_lock_sequencer;

  localparam int unsigned VBW = 8;
  localparam int unsigned CBW = 8;
  localparam int unsigned TBW = 16;
  localparam int unsigned MAXR = 3;
  localparam int unsigned RBW = 2;

  localparam int P_IDLE = 0, P_CLEAR = 1, P_ACQ = 2, P_LOCKED = 3, P_FAILED = 4;

  logic           clk = 1'b0;
  logic           clk_en, sync_rst, start_i, abort_i;
  logic [CBW-1:0] growth_rate_i, decay_rate_i, saturation_limit_i, plateau_limit_i;
  logic [TBW-1:0] timeout_cycles_i;
  logic           sample_valid_i;
  logic [VBW-1:0] sample_data_i;
  logic           prio_clear_state_o;
  logic [CBW-1:0] prio_growth_rate_o, prio_decay_rate_o, prio_saturation_limit_o, prio_plateau_limit_o;
  logic           prio_we_o;
  logic [VBW-1:0] prio_data_o;
  logic           prio_locked_in_i;
  logic [VBW-1:0] prio_data_i;
  logic           busy_o, locked_o, lock_lost_o, failed_o;
  logic [VBW-1:0] locked_value_o;
  logic [RBW-1:0] retry_count_o;

  value_lock_sequencer #(
    .VALUE_BIT_WIDTH(VBW), .COUNT_BIT_WIDTH(CBW), .TIMEOUT_BIT_WIDTH(TBW), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .start_i(start_i), .abort_i(abort_i),
    .growth_rate_i(growth_rate_i), .decay_rate_i(decay_rate_i),
    .saturation_limit_i(saturation_limit_i), .plateau_limit_i(plateau_limit_i),
    .timeout_cycles_i(timeout_cycles_i),
    .sample_valid_i(sample_valid_i), .sample_data_i(sample_data_i),
    .prio_clear_state_o(prio_clear_state_o),
    .prio_growth_rate_o(prio_growth_rate_o), .prio_decay_rate_o(prio_decay_rate_o),
    .prio_saturation_limit_o(prio_saturation_limit_o), .prio_plateau_limit_o(prio_plateau_limit_o),
    .prio_we_o(prio_we_o), .prio_data_o(prio_data_o),
    .prio_locked_in_i(prio_locked_in_i), .prio_data_i(prio_data_i),
    .busy_o(busy_o), .locked_o(locked_o), .locked_value_o(locked_value_o),
    .lock_lost_o(lock_lost_o), .failed_o(failed_o), .retry_count_o(retry_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase, elapsed cycles in the current attempt and its limit.
  int             m_st = P_IDLE;
  int             m_elapsed = 0;
  int             m_limit = 0;
  int             m_retry = 0;
  logic [VBW-1:0] m_lv = '0;
  bit             m_lost = 1'b0;
  logic [CBW-1:0] m_cfg [4] = '{default: '0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    m_lost = 1'b0;
    if (sync_rst) begin
      m_st = P_IDLE; m_elapsed = 0; m_limit = 0; m_retry = 0; m_lv = '0;
      m_cfg = '{default: '0};
    end else if (clk_en) begin
      if (m_st == P_LOCKED) m_lv = prio_data_i;
      if (abort_i) m_st = P_IDLE;
      else if (m_st == P_IDLE || m_st == P_FAILED) begin
        if (start_i) begin
          m_st = P_CLEAR; m_retry = 0;
          m_cfg = '{growth_rate_i, decay_rate_i, saturation_limit_i, plateau_limit_i};
        end
      end else if (m_st == P_CLEAR) begin
        m_st = P_ACQ; m_elapsed = 0; m_limit = int'(timeout_cycles_i);
      end else if (m_st == P_ACQ) begin
        if (prio_locked_in_i) m_st = P_LOCKED;
        else if (m_limit != 0) begin
          m_elapsed++;
          if (m_elapsed == m_limit) begin
            if (m_retry < int'(MAXR)) begin m_retry++; m_st = P_CLEAR; end
            else m_st = P_FAILED;
          end
        end
      end else if (m_st == P_LOCKED && !prio_locked_in_i) begin
        m_st = P_ACQ; m_lost = 1'b1; m_elapsed = 0; m_limit = int'(timeout_cycles_i); m_retry = 0;
      end
    end
  endtask

  task automatic compare_all();
    bit fwd;
    fwd = (m_st == P_ACQ) || (m_st == P_LOCKED);
    chk("busy", 32'(busy_o), 32'(m_st == P_CLEAR || fwd));
    chk("locked", 32'(locked_o), 32'(m_st == P_LOCKED));
    chk("failed", 32'(failed_o), 32'(m_st == P_FAILED));
    chk("clear", 32'(prio_clear_state_o), 32'(m_st == P_CLEAR));
    chk("we", 32'(prio_we_o), 32'(fwd & sample_valid_i));
    chk("data", 32'(prio_data_o), fwd ? 32'(sample_data_i) : 32'd0);
    chk("locked_value", 32'(locked_value_o), 32'(m_lv));
    chk("lock_lost", 32'(lock_lost_o), 32'(m_lost));
    chk("retry", 32'(retry_count_o), 32'(m_retry));
    chk("cfg_growth", 32'(prio_growth_rate_o), 32'(m_cfg[0]));
    chk("cfg_decay", 32'(prio_decay_rate_o), 32'(m_cfg[1]));
    chk("cfg_sat", 32'(prio_saturation_limit_o), 32'(m_cfg[2]));
    chk("cfg_plateau", 32'(prio_plateau_limit_o), 32'(m_cfg[3]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  int clears;

  initial begin
    clk_en = 1'b1; sync_rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    growth_rate_i = 8'h11; decay_rate_i = 8'h22; saturation_limit_i = 8'h33; plateau_limit_i = 8'h44;
    timeout_cycles_i = 16'd10; sample_valid_i = 1'b0; sample_data_i = '0;
    prio_locked_in_i = 1'b0; prio_data_i = '0;
    tick(); tick();
    sync_rst = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cfg", 32'(prio_growth_rate_o), 32'd0);

    // Reset in the middle of an acquisition.
    start_i = 1'b1; tick(); start_i = 1'b0; tick(); tick();
    chk("t1_in_acq", 32'(busy_o), 32'd1);
    sample_valid_i = 1'b1; sample_data_i = 8'hC3; sync_rst = 1'b1; tick(); sync_rst = 1'b0;
    chk("t1_busy", 32'(busy_o), 32'd0);
    chk("t1_we", 32'(prio_we_o), 32'd0);
    chk("t1_clear", 32'(prio_clear_state_o), 32'd0);
    chk("t1_cfg", 32'(prio_decay_rate_o), 32'd0);

    // Lock at the sixth acquisition cycle.
    timeout_cycles_i = 16'd10; sample_data_i = 8'h5A; prio_data_i = 8'h5A;
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("t2_clear_latency", 32'(prio_clear_state_o), 32'd1);
    tick();
    chk("t2_we_latency", 32'(prio_we_o), 32'd1);
    growth_rate_i = 8'hEE;
    for (int i = 0; i < 5; i++) tick();
    prio_locked_in_i = 1'b1; tick(); tick();
    chk("t2_locked", 32'(locked_o), 32'd1);
    chk("t2_value", 32'(locked_value_o), 32'h5A);
    chk("t2_retry", 32'(retry_count_o), 32'd0);
    chk("t2_cfg_stable", 32'(prio_growth_rate_o), 32'h11);

    // Lock loss: one pulse, back to acquire without clear, then relock.
    prio_locked_in_i = 1'b0; tick();
    chk("t4_lost", 32'(lock_lost_o), 32'd1);
    chk("t4_unlocked", 32'(locked_o), 32'd0);
    chk("t4_no_clear", 32'(prio_clear_state_o), 32'd0);
    tick();
    chk("t4_lost_once", 32'(lock_lost_o), 32'd0);
    chk("t4_no_clear2", 32'(prio_clear_state_o), 32'd0);
    prio_locked_in_i = 1'b1; tick();
    chk("t4_relock", 32'(locked_o), 32'd1);

    // Lock coinciding with timer expiry on the second attempt.
    abort_i = 1'b1; prio_locked_in_i = 1'b0; tick(); abort_i = 1'b0;
    chk("t5_idle", 32'(busy_o), 32'd0);
    timeout_cycles_i = 16'd3;
    start_i = 1'b1; tick(); start_i = 1'b0; tick();
    for (int i = 0; i < 3; i++) tick();
    chk("t5_retry_clear", 32'(prio_clear_state_o), 32'd1);
    tick(); tick(); tick();
    prio_locked_in_i = 1'b1; tick();
    chk("t5_locked", 32'(locked_o), 32'd1);
    chk("t5_retry", 32'(retry_count_o), 32'd1);

    // Retries exhausted: four clear pulses then FAILED.
    abort_i = 1'b1; prio_locked_in_i = 1'b0; tick(); abort_i = 1'b0;
    timeout_cycles_i = 16'd4; clears = 0;
    start_i = 1'b1;
    for (int i = 0; i < 60 && !failed_o; i++) begin
      tick(); start_i = 1'b0;
      if (prio_clear_state_o) begin
        clears++;
        chk("t3_retry_at_clear", 32'(retry_count_o), 32'(clears - 1));
      end
    end
    chk("t3_clears", 32'(clears), 32'd4);
    chk("t3_failed", 32'(failed_o), 32'd1);
    chk("t3_retry", 32'(retry_count_o), 32'd3);

    // Abort in CLEAR while clk_en is low takes effect at the next enabled edge.
    timeout_cycles_i = 16'd10; start_i = 1'b1; tick(); start_i = 1'b0;
    clk_en = 1'b0; abort_i = 1'b1; tick(); tick();
    chk("t6_hold_clear", 32'(prio_clear_state_o), 32'd1);
    clk_en = 1'b1; tick(); abort_i = 1'b0;
    chk("t6_idle", 32'(busy_o), 32'd0);
    start_i = 1'b1; tick(); start_i = 1'b0; tick();
    start_i = 1'b1; tick(); tick(); start_i = 1'b0;
    chk("t6_start_ignored", 32'(prio_clear_state_o), 32'd0);
    chk("t6_still_busy", 32'(busy_o), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      clk_en           = ($urandom_range(0, 99) < 85);
      sync_rst         = ($urandom_range(0, 999) < 4);
      start_i          = ($urandom_range(0, 99) < 10);
      abort_i          = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 10) prio_locked_in_i = ~prio_locked_in_i;
      if ($urandom_range(0, 99) < 5) timeout_cycles_i = TBW'($urandom_range(0, 8));
      growth_rate_i      = CBW'($urandom);
      decay_rate_i       = CBW'($urandom);
      saturation_limit_i = CBW'($urandom);
      plateau_limit_i    = CBW'($urandom);
      sample_valid_i     = 1'($urandom);
      sample_data_i      = VBW'($urandom);
      prio_data_i        = VBW'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
